// File: rtl/alu_arbiter_ctrl.sv
// Two-requester front end for a shared combinational ALU.
// Round-robin grant, operand/result registers, saturating status counters.
module alu_arbiter_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [2:0]         req0_opcode,
  input  logic [WIDTH-1:0]   req0_in1,
  input  logic [WIDTH-1:0]   req0_in2,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [2:0]         req1_opcode,
  input  logic [WIDTH-1:0]   req1_in1,
  input  logic [WIDTH-1:0]   req1_in2,
  output logic [WIDTH-1:0]   alu_in1,
  output logic [WIDTH-1:0]   alu_in2,
  output logic [2:0]         alu_opcode,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_zero,
  input  logic               alu_error,
  input  logic               alu_invalid,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               rsp_zero,
  output logic               rsp_error,
  output logic               rsp_invalid,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count,
  output logic [CNT_W-1:0]   err_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state, state_nx;
  logic   ptr;
  logic   gnt0, gnt1;
  logic   accept;

  // ptr=0 favours requester 0 on a tie
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      req0_valid && req1_valid: begin
        gnt0 = !ptr;
        gnt1 = ptr;
      end
      req0_valid && !req1_valid: gnt0 = 1'b1;
      !req0_valid && req1_valid: gnt1 = 1'b1;
      default: ;
    endcase
  end

  assign req0_ready = (state == IDLE) && gnt0;
  assign req1_ready = (state == IDLE) && gnt1;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = EXEC;
      EXEC: state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= 1'b0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_opcode  <= '0;
      rsp_id      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_zero    <= 1'b0;
      rsp_error   <= 1'b0;
      rsp_invalid <= 1'b0;
      op_count    <= '0;
      err_count   <= '0;
    end else begin
      if (accept) begin
        alu_opcode <= gnt1 ? req1_opcode : req0_opcode;
        alu_in1    <= gnt1 ? req1_in1 : req0_in1;
        alu_in2    <= gnt1 ? req1_in2 : req0_in2;
        rsp_id     <= gnt1;
        ptr        <= !gnt1;
      end
      if (state == EXEC) begin
        rsp_valid   <= 1'b1;
        rsp_data    <= alu_out;
        rsp_zero    <= alu_zero;
        rsp_error   <= alu_error;
        rsp_invalid <= alu_invalid;
        if (op_count != '1)
          op_count <= op_count + CNT_W'(1);
        if (alu_error && err_count != '1)
          err_count <= err_count + CNT_W'(1);
      end
      if (state == RESP && rsp_ready)
        rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Directed bench for alu_arbiter_ctrl with a behavioural ALU.
// ALU: 0 add, 1 sub, 2 mul, 3 div (div-by-0 error), 4-7 invalid.
module tb_alu_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_opcode, req1_opcode;
  logic [7:0]  req0_in1, req0_in2, req1_in1, req1_in2;
  logic [7:0]  alu_in1, alu_in2;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_out;
  logic        alu_zero, alu_error, alu_invalid;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_zero, rsp_error, rsp_invalid;
  logic        busy;
  logic [15:0] op_count, err_count;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  alu_arbiter_ctrl #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_opcode(req0_opcode), .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_opcode(req1_opcode), .req1_in1(req1_in1), .req1_in2(req1_in2),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .alu_error(alu_error), .alu_invalid(alu_invalid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_error(rsp_error), .rsp_invalid(rsp_invalid),
    .busy(busy), .op_count(op_count), .err_count(err_count)
  );

  always_comb begin
    alu_out     = 16'h0000;
    alu_error   = 1'b0;
    alu_invalid = 1'b0;
    case (alu_opcode)
      3'd0: alu_out = {8'h00, alu_in1} + {8'h00, alu_in2};
      3'd1: alu_out = {8'h00, alu_in1} - {8'h00, alu_in2};
      3'd2: alu_out = {8'h00, alu_in1} * {8'h00, alu_in2};
      3'd3: begin
        if (alu_in2 == 8'h00) begin
          alu_out   = 16'hFFFF;
          alu_error = 1'b1;
        end else begin
          alu_out = {8'h00, alu_in1 / alu_in2};
        end
      end
      default: begin
        alu_out     = 16'hFFFF;
        alu_error   = 1'b1;
        alu_invalid = 1'b1;
      end
    endcase
    alu_zero = (alu_out == 16'h0000);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in RESP with the response visible.
  task automatic issue(input bit id, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b);
    int n;
    if (id) begin
      req1_opcode = op; req1_in1 = a; req1_in2 = b; req1_valid = 1'b1;
    end else begin
      req0_opcode = op; req0_in1 = a; req0_in2 = b; req0_valid = 1'b1;
    end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 10) begin
      cyc();
      n++;
    end
    chk("issue_wait", 32'(n < 10), 32'd1);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n0, n1, ng, nr, last_t, t;
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_opcode = 0; req0_in1 = 0; req0_in2 = 0;
    req1_opcode = 0; req1_in1 = 0; req1_in2 = 0;
    cyc(); cyc();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_alu_in1", 32'(alu_in1), 32'd0);
    rst = 1'b0;

    // single op from requester 0, with timing
    req0_opcode = 3'd0; req0_in1 = 8'd200; req0_in2 = 8'd100;
    req0_valid = 1'b1;
    #1;
    chk("t1_req0_ready", 32'(req0_ready), 32'd1);
    chk("t1_req1_ready", 32'(req1_ready), 32'd0);
    cyc();
    req0_valid = 1'b0;
    chk("t1_exec_busy", 32'(busy), 32'd1);
    chk("t1_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t1_alu_in1", 32'(alu_in1), 32'd200);
    chk("t1_alu_in2", 32'(alu_in2), 32'd100);
    cyc();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_data", 32'(rsp_data), 32'h012C);
    chk("t1_rsp_id", 32'(rsp_id), 32'd0);
    chk("t1_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("t1_rsp_error", 32'(rsp_error), 32'd0);
    chk("t1_op_count", 32'(op_count), 32'd1);
    ack();
    chk("t1_done_valid", 32'(rsp_valid), 32'd0);
    chk("t1_done_busy", 32'(busy), 32'd0);
    chk("t1_data_kept", 32'(rsp_data), 32'h012C);

    // divide by zero, then a good divide
    issue(1'b1, 3'd3, 8'd50, 8'd0);
    chk("t2_div0_data", 32'(rsp_data), 32'hFFFF);
    chk("t2_div0_error", 32'(rsp_error), 32'd1);
    chk("t2_div0_id", 32'(rsp_id), 32'd1);
    chk("t2_err_count", 32'(err_count), 32'd1);
    ack();
    issue(1'b1, 3'd3, 8'd50, 8'd7);
    chk("t2_div_data", 32'(rsp_data), 32'd7);
    chk("t2_div_error", 32'(rsp_error), 32'd0);
    chk("t2_err_hold", 32'(err_count), 32'd1);
    chk("t2_op_count", 32'(op_count), 32'd3);
    ack();

    // both requesters saturating the port
    rsp_ready = 1'b1;
    req0_opcode = 3'd0; req1_opcode = 3'd0;
    req0_in2 = 8'd1; req1_in2 = 8'd1;
    n0 = 0; n1 = 0; ng = 0; nr = 0; last_t = -100;
    for (t = 0; t < 60 && nr < 8; t++) begin
      req0_valid = (n0 < 4);
      req1_valid = (n1 < 4);
      req0_in1 = 8'(ng);
      req1_in1 = 8'(ng);
      #1;
      if (rsp_valid) begin
        chk("t3_rsp_id", 32'(rsp_id), 32'(nr % 2));
        chk("t3_rsp_data", 32'(rsp_data), 32'(nr + 1));
        chk("t3_rsp_gap", 32'(t - last_t >= 3), 32'd1);
        last_t = t;
        nr++;
      end
      if (req0_ready || req1_ready) begin
        chk("t3_grant", 32'(req1_ready), 32'(ng % 2));
        if (req0_ready) n0++;
        if (req1_ready) n1++;
        ng++;
      end
      cyc();
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    chk("t3_responses", 32'(nr), 32'd8);
    chk("t3_op_count", 32'(op_count), 32'd11);

    // response backpressure
    issue(1'b0, 3'd2, 8'd3, 8'd4);
    req0_opcode = 3'd0; req0_in1 = 8'd1; req0_in2 = 8'd1;
    req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_data", 32'(rsp_data), 32'd12);
      chk("t4_hold_busy", 32'(busy), 32'd1);
      chk("t4_hold_ready", 32'(req0_ready), 32'd0);
      cyc();
    end
    ack();
    chk("t4_idle_busy", 32'(busy), 32'd0);
    chk("t4_idle_ready", 32'(req0_ready), 32'd1);
    cyc();
    req0_valid = 1'b0;
    chk("t4_accept_busy", 32'(busy), 32'd1);
    chk("t4_accept_in1", 32'(alu_in1), 32'd1);
    cyc();
    chk("t4_rsp_data", 32'(rsp_data), 32'd2);
    ack();

    // invalid opcode and zero result
    issue(1'b1, 3'd5, 8'd1, 8'd2);
    chk("t5_inv_data", 32'(rsp_data), 32'hFFFF);
    chk("t5_inv_error", 32'(rsp_error), 32'd1);
    chk("t5_inv_invalid", 32'(rsp_invalid), 32'd1);
    chk("t5_inv_opcode", 32'(alu_opcode), 32'd5);
    chk("t5_err_count", 32'(err_count), 32'd2);
    ack();
    issue(1'b0, 3'd1, 8'd9, 8'd9);
    chk("t5_sub_data", 32'(rsp_data), 32'd0);
    chk("t5_sub_zero", 32'(rsp_zero), 32'd1);
    chk("t5_sub_error", 32'(rsp_error), 32'd0);
    chk("t5_sub_invalid", 32'(rsp_invalid), 32'd0);
    chk("t5_op_count", 32'(op_count), 32'd15);
    ack();

    // reset in EXEC
    req0_opcode = 3'd0; req0_in1 = 8'd5; req0_in2 = 8'd6;
    req0_valid = 1'b1;
    cyc();
    req0_valid = 1'b0;
    chk("t6_exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6a_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6a_busy", 32'(busy), 32'd0);
    chk("t6a_op_count", 32'(op_count), 32'd0);
    chk("t6a_err_count", 32'(err_count), 32'd0);
    chk("t6a_alu_in1", 32'(alu_in1), 32'd0);
    cyc();
    chk("t6a_no_rsp", 32'(rsp_valid), 32'd0);

    // reset in RESP, after a req0 grant moved the pointer
    issue(1'b0, 3'd0, 8'd2, 8'd3);
    chk("t6b_pre_valid", 32'(rsp_valid), 32'd1);
    chk("t6b_pre_count", 32'(op_count), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6b_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6b_busy", 32'(busy), 32'd0);
    chk("t6b_op_count", 32'(op_count), 32'd0);
    chk("t6b_rsp_data", 32'(rsp_data), 32'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("t6b_grant0", 32'(req0_ready), 32'd1);
    chk("t6b_grant1", 32'(req1_ready), 32'd0);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("t6b_rsp_id", 32'(rsp_id), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
